// File: rtl/switch_pkg.sv
// Shared types and constants for the slide-switch conditioning front end.
package switch_pkg;

  // Auto-repeat sequencer states for the increase/decrease channels.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  // Defaults sized for a 50 MHz clk: 10 ms debounce, 0.5 s first repeat, 0.1 s repeat.
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  // Channel positions inside sw_stable and the internal per-channel vectors.
  localparam int CH_INC = 0;
  localparam int CH_DEC = 1;
  localparam int CH_SS  = 2;
  localparam int NUM_CH = 3;

  // Larger of two integers; sizes the shared repeat counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// One switch channel: 2-flop synchroniser followed by a level debouncer.
// o_stable only changes after the synchronised level has disagreed with it
// for DEBOUNCE_CYCLES consecutive clocks.
module switch_debounce
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  // Bring the asynchronous switch level into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_raw};
    end
  end

  // Count consecutive disagreements; accept the new level on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (r_sync[1] == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_stable <= r_sync[1];
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/switch_conditioner.sv
// Turns the three raw slide switches into single-cycle command pulses.
// Increase/decrease auto-repeat while held; start/stop fires once per press.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for a fresh debounced press (rising edge)
//   DELAY  | first pulse sent, counting REPEAT_DELAY to the first repeat
//   REPEAT | repeating, one pulse every REPEAT_PERIOD cycles
//
// Holding increase and decrease together parks both sequencers in IDLE;
// only a new press of a switch restarts its sequence.
module switch_conditioner
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_increase,
  input  logic       sw_decrease,
  input  logic       sw_start_stop,
  output logic       swt_increase,
  output logic       swt_decrease,
  output logic       swt_start_stop,
  output logic [2:0] sw_stable
);

  localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [NUM_CH-1:0] w_raw;
  logic [NUM_CH-1:0] w_stable;
  logic [NUM_CH-1:0] r_stable_d;
  logic [NUM_CH-1:0] w_rise;
  logic              w_conflict;

  rep_state_t        r_state     [2];
  rep_state_t        w_state_nxt [2];
  logic [RW-1:0]     r_cnt       [2];
  logic [RW-1:0]     w_cnt_nxt   [2];
  logic [1:0]        w_fire;

  logic              r_swt_inc;
  logic              r_swt_dec;
  logic              r_swt_ss;

  assign w_raw[CH_INC] = sw_increase;
  assign w_raw[CH_DEC] = sw_decrease;
  assign w_raw[CH_SS]  = sw_start_stop;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_deb
    switch_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .rst      (rst),
      .i_raw    (w_raw[g]),
      .o_stable (w_stable[g])
    );
  end

  // Delayed copy of the debounced levels for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stable_d <= '0;
    end else begin
      r_stable_d <= w_stable;
    end
  end

  assign w_rise     = w_stable & ~r_stable_d;
  assign w_conflict = w_stable[CH_INC] & w_stable[CH_DEC];

  // Repeat sequencer state and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        r_state[c] <= IDLE;
        r_cnt[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        r_state[c] <= w_state_nxt[c];
        r_cnt[c]   <= w_cnt_nxt[c];
      end
    end
  end

  // Next state: release or conflict wins over everything, else follow the timers.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      w_state_nxt[c] = r_state[c];
      w_cnt_nxt[c]   = r_cnt[c] + 1'b1;
      if (!w_stable[c] || w_conflict) begin
        w_state_nxt[c] = IDLE;
        w_cnt_nxt[c]   = '0;
      end else begin
        case (r_state[c])
          IDLE: begin
            w_cnt_nxt[c] = '0;
            if (w_rise[c]) begin
              w_state_nxt[c] = DELAY;
            end
          end
          DELAY: begin
            if (r_cnt[c] == DELAY_LAST) begin
              w_state_nxt[c] = REPEAT;
              w_cnt_nxt[c]   = '0;
            end
          end
          REPEAT: begin
            if (r_cnt[c] == PERIOD_LAST) begin
              w_cnt_nxt[c] = '0;
            end
          end
          default: begin
            w_state_nxt[c] = IDLE;
            w_cnt_nxt[c]   = '0;
          end
        endcase
      end
    end
  end

  // Pulse request: press edge in IDLE, or a timer expiring while held.
  always_comb begin
    w_fire = 2'b00;
    for (int c = 0; c < 2; c++) begin
      if (w_stable[c] && !w_conflict) begin
        case (r_state[c])
          IDLE:    w_fire[c] = w_rise[c];
          DELAY:   w_fire[c] = (r_cnt[c] == DELAY_LAST);
          REPEAT:  w_fire[c] = (r_cnt[c] == PERIOD_LAST);
          default: w_fire[c] = 1'b0;
        endcase
      end
    end
  end

  // Registered command pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_swt_inc <= 1'b0;
      r_swt_dec <= 1'b0;
      r_swt_ss  <= 1'b0;
    end else begin
      r_swt_inc <= w_fire[CH_INC];
      r_swt_dec <= w_fire[CH_DEC];
      r_swt_ss  <= w_rise[CH_SS];
    end
  end

  assign swt_increase   = r_swt_inc;
  assign swt_decrease   = r_swt_dec;
  assign swt_start_stop = r_swt_ss;
  assign sw_stable      = w_stable;

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner: directed scenarios plus random switch activity,
// all checked every cycle against a pulse-schedule reference model.
`timescale 1ns/1ps
module tb_switch_conditioner;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw_increase = 1'b0;
  logic       sw_decrease = 1'b0;
  logic       sw_start_stop = 1'b0;
  logic       swt_increase;
  logic       swt_decrease;
  logic       swt_start_stop;
  logic [2:0] sw_stable;

  switch_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sw_increase    (sw_increase),
    .sw_decrease    (sw_decrease),
    .sw_start_stop  (sw_start_stop),
    .swt_increase   (swt_increase),
    .swt_decrease   (swt_decrease),
    .swt_start_stop (swt_start_stop),
    .sw_stable      (sw_stable)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each raw level reaches the filter two samples late; a level is accepted
  // after D consecutive disagreeing samples. Pulses follow a schedule: one on
  // the press edge, the next RD cycles later, then every RP cycles.
  int         n_edge = 0;
  logic [2:0] h0 = '0, h1 = '0;
  logic [2:0] m_stab = '0, m_stab_d = '0, m_out = '0;
  int         run_len [3];
  bit         armed   [2];
  int         age     [2];
  int         npulse  [2];

  always @(posedge clk) begin
    logic [2:0] rise;
    logic       conflict;
    logic [2:0] raw;
    n_edge++;
    raw = {sw_start_stop, sw_decrease, sw_increase};
    if (rst) begin
      h0 = '0; h1 = '0; m_stab = '0; m_stab_d = '0; m_out = '0;
      for (int c = 0; c < 3; c++) run_len[c] = 0;
      for (int c = 0; c < 2; c++) begin armed[c] = 0; age[c] = 0; npulse[c] = 0; end
    end else begin
      rise     = m_stab & ~m_stab_d;
      conflict = m_stab[0] & m_stab[1];
      for (int c = 0; c < 2; c++) begin
        m_out[c] = 1'b0;
        if (!m_stab[c] || conflict) begin
          armed[c] = 0;
        end else if (armed[c]) begin
          age[c]++;
          if (age[c] == ((npulse[c] == 1) ? RD : RP)) begin
            m_out[c] = 1'b1;
            age[c] = 0;
            npulse[c]++;
          end
        end else if (rise[c]) begin
          m_out[c] = 1'b1;
          armed[c] = 1;
          age[c] = 0;
          npulse[c] = 1;
        end
      end
      m_out[2] = rise[2];
      m_stab_d = m_stab;
      for (int c = 0; c < 3; c++) begin
        if (h1[c] != m_stab[c]) begin
          run_len[c]++;
          if (run_len[c] == D) begin
            m_stab[c] = h1[c];
            run_len[c] = 0;
          end
        end else begin
          run_len[c] = 0;
        end
      end
      h1 = h0;
      h0 = raw;
    end
  end

  // ---------------- monitor / pulse recorder ----------------
  bit         mon_en = 0;
  bit         rec = 0;
  int         t0 = 0;
  int         q_inc[$], q_dec[$], q_ss[$];
  int         first_s2 = -1;
  logic [2:0] stab_or = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      check_val("swt_increase", swt_increase, m_out[0]);
      check_val("swt_decrease", swt_decrease, m_out[1]);
      check_val("swt_start_stop", swt_start_stop, m_out[2]);
      check_val("sw_stable", sw_stable, m_stab);
      check_val("inc_dec_exclusive", swt_increase & swt_decrease, 0);
      if (rec) begin
        if (swt_increase)   q_inc.push_back(n_edge - t0 + 1);
        if (swt_decrease)   q_dec.push_back(n_edge - t0 + 1);
        if (swt_start_stop) q_ss.push_back(n_edge - t0 + 1);
        if (sw_stable[2] && first_s2 < 0) first_s2 = n_edge - t0 + 1;
        stab_or = stab_or | sw_stable;
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a falling edge: the next rising edge is cycle 0.
  task automatic start_rec();
    t0 = n_edge + 1;
    q_inc.delete(); q_dec.delete(); q_ss.delete();
    first_s2 = -1;
    stab_or = '0;
    rec = 1;
  endtask

  task automatic check_q(input string tag, input int got[$], input int exp[$]);
    check_val({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check_val($sformatf("%s[%0d]", tag, i), (i < got.size()) ? got[i] : -1, exp[i]);
  endtask

  initial begin
    int e[$];
    int hold;
    rst = 1'b1;
    run(3);
    mon_en = 1;
    check_val("rst_inc", swt_increase, 0);
    check_val("rst_dec", swt_decrease, 0);
    check_val("rst_ss", swt_start_stop, 0);
    check_val("rst_stable", sw_stable, 0);
    rst = 1'b0;
    run(5);

    // glitch shorter than the debounce window
    start_rec();
    sw_increase = 1'b1; run(3);
    sw_increase = 1'b0; run(20);
    e.delete();
    check_q("glitch_inc", q_inc, e);
    check_q("glitch_dec", q_dec, e);
    check_q("glitch_ss", q_ss, e);
    check_val("glitch_stable", stab_or, 0);
    run(5);

    // single start/stop press
    start_rec();
    sw_start_stop = 1'b1; run(30);
    sw_start_stop = 1'b0; run(15);
    e = '{7};
    check_q("single_ss", q_ss, e);
    check_val("single_stable2_from", first_s2, 6);
    run(10);

    // increase held long enough to auto-repeat
    start_rec();
    sw_increase = 1'b1; run(38);
    sw_increase = 1'b0; run(20);
    e = '{7, 27, 32, 37, 42};
    check_q("repeat_inc", q_inc, e);
    e.delete();
    check_q("repeat_dec", q_dec, e);
    run(10);

    // both held: nothing, and the survivor stays silent until re-pressed
    start_rec();
    sw_increase = 1'b1; run(10);
    sw_decrease = 1'b1; run(30);
    sw_decrease = 1'b0; run(30);
    e = '{7};
    check_q("conflict_inc", q_inc, e);
    e.delete();
    check_q("conflict_dec", q_dec, e);
    sw_increase = 1'b0; run(15);
    start_rec();
    sw_increase = 1'b1; run(10);
    sw_increase = 1'b0; run(15);
    e = '{7};
    check_q("repress_inc", q_inc, e);
    run(10);

    // reset while decrease is repeating
    start_rec();
    sw_decrease = 1'b1; run(30);
    rst = 1'b1; run(1);
    check_val("midrst_dec", swt_decrease, 0);
    check_val("midrst_inc", swt_increase, 0);
    check_val("midrst_ss", swt_start_stop, 0);
    check_val("midrst_stable", sw_stable, 0);
    rst = 1'b0; run(40);
    e = '{7, 27, 38, 58, 63, 68};
    check_q("midrst_dec", q_dec, e);
    sw_decrease = 1'b0; run(20);

    // long reset with every switch already high
    rec = 0;
    sw_increase = 1'b1; sw_decrease = 1'b1; sw_start_stop = 1'b1;
    rst = 1'b1; run(5);
    start_rec();
    rst = 1'b0; run(30);
    e = '{7};
    check_q("postrst_ss", q_ss, e);
    e.delete();
    check_q("postrst_inc", q_inc, e);
    check_q("postrst_dec", q_dec, e);
    check_val("postrst_stable2_from", first_s2, 6);
    sw_increase = 1'b0; sw_decrease = 1'b0; sw_start_stop = 1'b0;
    run(20);
    rec = 0;

    // random activity, checked cycle by cycle against the model
    for (int seg = 0; seg < 120; seg++) begin
      {sw_start_stop, sw_decrease, sw_increase} = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        run($urandom_range(1, 3));
        rst = 1'b0;
      end
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(40, 60) : $urandom_range(1, 12);
      run(hold);
    end
    sw_increase = 1'b0; sw_decrease = 1'b0; sw_start_stop = 1'b0;
    run(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
